// File: rtl/spi_target_if.sv
// Pin and register-bus bundle for spi_target: SPI pins toward the initiator,
// byte-wide register bus toward the local register file.
interface spi_target_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // The target: samples SPI pins and rdata, drives MISO and the register strobes.
    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        input  reg_rdata,
        output spi_miso,
        output spi_miso_oe,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re
    );

    // The environment: SPI initiator plus register file responder.
    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        output reg_rdata,
        input  spi_miso,
        input  spi_miso_oe,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target bridging an oversampled SPI frame (command byte + data bytes,
// auto-incrementing 7-bit address) onto a byte-wide register bus in the clk24 domain.
module spi_target (
    input  logic         i_clk24,
    input  logic         i_reset,
    spi_target_if.slave  io_bus
);

    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_t;

    // Pin synchronisers are deliberately unreset so that a reset cannot fake a cs_n high.
    logic [2:0] r_sclk_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge i_clk24) begin
        r_sclk_sync <= {r_sclk_sync[1:0], io_bus.spi_sclk};
        r_cs_sync   <= {r_cs_sync[0], io_bus.spi_cs_n};
        r_mosi_sync <= {r_mosi_sync[0], io_bus.spi_mosi};
    end

    logic       w_cs_n;
    logic       w_mosi;
    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_rx_byte;

    state_t     r_state;
    logic       r_armed;
    logic [6:0] r_addr;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sr;
    logic [7:0] r_tx_byte;
    logic       r_rd_pend;
    logic       r_miso;
    logic       r_miso_oe;
    logic [6:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_reg_re;

    assign w_cs_n    = r_cs_sync[1];
    assign w_mosi    = r_mosi_sync[1];
    assign w_rise    = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_fall    = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_rx_byte = {r_rx_sr[6:0], w_mosi};

    always_ff @(posedge i_clk24) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_armed     <= 1'b0;
            r_addr      <= 7'h00;
            r_bit_cnt   <= 3'd0;
            r_rx_sr     <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_rd_pend   <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_reg_addr  <= 7'h00;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
        end else begin
            r_reg_we  <= 1'b0;
            r_reg_re  <= 1'b0;
            r_rd_pend <= r_reg_re;
            r_miso_oe <= ~w_cs_n;
            if (r_rd_pend) begin
                r_tx_byte <= io_bus.reg_rdata;
            end

            if (w_cs_n) begin
                // Deselect aborts any partial byte; a new frame needs cs_n seen high first.
                r_state   <= StIdle;
                r_armed   <= 1'b1;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (r_armed) begin
                            r_state   <= StCmd;
                            r_bit_cnt <= 3'd0;
                            r_rx_sr   <= 8'h00;
                            r_tx_byte <= 8'h00;
                            r_miso    <= 1'b0;
                        end
                    end
                    default: begin
                        if (w_rise) begin
                            r_rx_sr   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                case (r_state)
                                    StCmd: begin
                                        r_addr <= w_rx_byte[6:0];
                                        if (w_rx_byte[7]) begin
                                            r_reg_addr <= w_rx_byte[6:0];
                                            r_reg_re   <= 1'b1;
                                            r_state    <= StRdata;
                                        end else begin
                                            r_state <= StWdata;
                                        end
                                    end
                                    StWdata: begin
                                        r_reg_addr  <= r_addr;
                                        r_reg_wdata <= w_rx_byte;
                                        r_reg_we    <= 1'b1;
                                        r_addr      <= r_addr + 7'd1;
                                    end
                                    default: begin
                                        // Prefetch the next address so it is ready at the byte boundary.
                                        r_addr     <= r_addr + 7'd1;
                                        r_reg_addr <= r_addr + 7'd1;
                                        r_reg_re   <= 1'b1;
                                    end
                                endcase
                            end
                        end else if (w_fall) begin
                            r_miso <= r_tx_byte[3'd7 - r_bit_cnt];
                        end
                    end
                endcase
            end
        end
    end

    assign io_bus.spi_miso    = r_miso;
    assign io_bus.spi_miso_oe = r_miso_oe;
    assign io_bus.reg_addr    = r_reg_addr;
    assign io_bus.reg_wdata   = r_reg_wdata;
    assign io_bus.reg_we      = r_reg_we;
    assign io_bus.reg_re      = r_reg_re;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI initiator at clk/8 plus a register-file
// responder returning addr ^ 0x5A one cycle after each read strobe.
module tb_spi_target;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    spi_target_if bus ();

    spi_target dut (
        .i_clk24 (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.reg_re) bus.reg_rdata <= {1'b0, bus.reg_addr} ^ 8'h5A;
    end

    logic [6:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [6:0] re_addr_q[$];

    always @(negedge clk) begin
        if (!reset && bus.reg_we) begin
            we_addr_q.push_back(bus.reg_addr);
            we_data_q.push_back(bus.reg_wdata);
        end
        if (!reset && bus.reg_re) re_addr_q.push_back(bus.reg_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of tx MSB first; returns MISO sampled just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi = tx[i];
            tick(4);
            rx[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            tick(4);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        tick(6);
        bus.spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic clear_log();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
    endtask

    initial begin
        logic [7:0] rx;

        reset          = 1'b1;
        bus.spi_sclk   = 1'b0;
        bus.spi_cs_n   = 1'b1;
        bus.spi_mosi   = 1'b0;
        bus.reg_rdata  = 8'h00;
        tick(5);
        check("rst_miso", 32'(bus.spi_miso), 32'h0);
        check("rst_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("rst_addr", 32'(bus.reg_addr), 32'h0);
        check("rst_wdata", 32'(bus.reg_wdata), 32'h0);
        check("rst_we", 32'(bus.reg_we), 32'h0);
        check("rst_re", 32'(bus.reg_re), 32'h0);
        reset = 1'b0;
        tick(4);

        // Burst write
        clear_log();
        cs_low();
        check("wr_oe", 32'(bus.spi_miso_oe), 32'h1);
        spi_byte(8'h05, rx);
        spi_byte(8'hA5, rx);
        spi_byte(8'h3C, rx);
        cs_high();
        check("wr_count", 32'(we_addr_q.size()), 32'd2);
        check("wr_re_count", 32'(re_addr_q.size()), 32'd0);
        if (we_addr_q.size() == 2) begin
            check("wr0_addr", 32'(we_addr_q[0]), 32'h05);
            check("wr0_data", 32'(we_data_q[0]), 32'hA5);
            check("wr1_addr", 32'(we_addr_q[1]), 32'h06);
            check("wr1_data", 32'(we_data_q[1]), 32'h3C);
        end

        // Burst read
        clear_log();
        cs_low();
        spi_byte(8'h90, rx);
        check("rd_byte0", 32'(rx), 32'h00);
        spi_byte(8'h00, rx);
        check("rd_byte1", 32'(rx), 32'h4A);
        spi_byte(8'h00, rx);
        check("rd_byte2", 32'(rx), 32'h4B);
        cs_high();
        check("rd_oe_off", 32'(bus.spi_miso_oe), 32'h0);
        check("rd_we_count", 32'(we_addr_q.size()), 32'd0);
        check("rd_re_count", 32'(re_addr_q.size()), 32'd3);
        if (re_addr_q.size() == 3) begin
            check("rd_re0", 32'(re_addr_q[0]), 32'h10);
            check("rd_re1", 32'(re_addr_q[1]), 32'h11);
            check("rd_re2", 32'(re_addr_q[2]), 32'h12);
        end

        // Address wrap
        clear_log();
        cs_low();
        spi_byte(8'h7F, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_high();
        check("wrap_count", 32'(we_addr_q.size()), 32'd2);
        if (we_addr_q.size() == 2) begin
            check("wrap0_addr", 32'(we_addr_q[0]), 32'h7F);
            check("wrap0_data", 32'(we_data_q[0]), 32'h11);
            check("wrap1_addr", 32'(we_addr_q[1]), 32'h00);
            check("wrap1_data", 32'(we_data_q[1]), 32'h22);
        end

        // Aborted byte
        clear_log();
        cs_low();
        spi_byte(8'h03, rx);
        spi_bits(8'hFF, 5, rx);
        cs_high();
        check("abort_we_count", 32'(we_addr_q.size()), 32'd0);
        cs_low();
        spi_byte(8'h01, rx);
        spi_byte(8'h77, rx);
        cs_high();
        check("abort_next_count", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() == 1) begin
            check("abort_next_addr", 32'(we_addr_q[0]), 32'h01);
            check("abort_next_data", 32'(we_data_q[0]), 32'h77);
        end

        // Reset mid-frame
        clear_log();
        cs_low();
        spi_byte(8'h02, rx);
        spi_bits(8'hC3, 3, rx);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_miso", 32'(bus.spi_miso), 32'h0);
        check("mid_rst_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("mid_rst_addr", 32'(bus.reg_addr), 32'h0);
        check("mid_rst_wdata", 32'(bus.reg_wdata), 32'h0);
        check("mid_rst_we", 32'(bus.reg_we), 32'h0);
        check("mid_rst_re", 32'(bus.reg_re), 32'h0);
        spi_bits(8'h18, 5, rx);
        spi_byte(8'h5A, rx);
        cs_high();
        check("mid_rst_no_we", 32'(we_addr_q.size()), 32'd0);
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h99, rx);
        cs_high();
        check("mid_rst_next_count", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() == 1) begin
            check("mid_rst_next_addr", 32'(we_addr_q[0]), 32'h02);
            check("mid_rst_next_data", 32'(we_data_q[0]), 32'h99);
        end

        // Deselected activity
        clear_log();
        for (int i = 0; i < 16; i++) begin
            bus.spi_mosi = i[0];
            bus.spi_sclk = ~bus.spi_sclk;
            tick(4);
            check("desel_oe", 32'(bus.spi_miso_oe), 32'h0);
            check("desel_miso", 32'(bus.spi_miso), 32'h0);
        end
        tick(6);
        check("desel_we", 32'(we_addr_q.size()), 32'd0);
        check("desel_re", 32'(re_addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
